// File: rtl/eth_frame_demux_if.sv
// Bundled stream-side and port-side signals of the Ethernet frame demultiplexer.
// select is one bit wider than log2(M_COUNT) when M_COUNT is a power of two, so out-of-range ports can be named.
interface eth_frame_demux_if #(
  parameter int unsigned M_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned SEL_W = $clog2(M_COUNT + 1);

  logic                  enable;
  logic                  drop;
  logic [SEL_W-1:0]      select;

  logic                  s_eth_hdr_valid;
  logic                  s_eth_hdr_ready;
  logic [47:0]           s_eth_dest_mac;
  logic [47:0]           s_eth_src_mac;
  logic [15:0]           s_eth_type;
  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata;
  logic                  s_eth_payload_axis_tvalid;
  logic                  s_eth_payload_axis_tready;
  logic                  s_eth_payload_axis_tlast;
  logic [USER_WIDTH-1:0] s_eth_payload_axis_tuser;

  logic [M_COUNT-1:0]    m_eth_hdr_valid;
  logic [M_COUNT-1:0]    m_eth_hdr_ready;
  logic [47:0]           m_eth_dest_mac;
  logic [47:0]           m_eth_src_mac;
  logic [15:0]           m_eth_type;
  logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata;
  logic [M_COUNT-1:0]    m_eth_payload_axis_tvalid;
  logic [M_COUNT-1:0]    m_eth_payload_axis_tready;
  logic                  m_eth_payload_axis_tlast;
  logic [USER_WIDTH-1:0] m_eth_payload_axis_tuser;

  // Demux side: consumes the input stream, sources the per-port outputs.
  modport slave (
    input  enable, drop, select,
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready,
    output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    output m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
    output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
    input  m_eth_hdr_ready, m_eth_payload_axis_tready
  );

  // Environment side: upstream source plus downstream consumers.
  modport master (
    output enable, drop, select,
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready,
    input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
    input  m_eth_payload_axis_tdata, m_eth_payload_axis_tvalid,
    input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
    output m_eth_hdr_ready, m_eth_payload_axis_tready
  );
endinterface

// File: rtl/eth_frame_demux.sv
// 1:M_COUNT Ethernet frame demultiplexer: the port is picked at the header handshake and
// held for the whole frame; header and payload each pass through one register stage.
module eth_frame_demux #(
  parameter int unsigned M_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  eth_frame_demux_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(M_COUNT + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                state, state_next;
  logic [SEL_W-1:0]      sel_reg;
  logic                  drop_reg;
  logic [M_COUNT-1:0]    hdr_valid_reg;
  logic [M_COUNT-1:0]    pay_valid_reg;
  logic [47:0]           dest_mac_reg;
  logic [47:0]           src_mac_reg;
  logic [15:0]           type_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tlast_reg;
  logic [USER_WIDTH-1:0] tuser_reg;

  logic hdr_ready, pay_ready, hdr_fire, pay_fire, stage_ready, hdr_discard;

  // The stage drains to the port it was loaded for, which may differ from sel_reg once a new frame starts.
  assign stage_ready = |(pay_valid_reg & bus.m_eth_payload_axis_tready);
  assign hdr_fire    = bus.s_eth_hdr_valid && hdr_ready;
  assign pay_fire    = bus.s_eth_payload_axis_tvalid && pay_ready;
  assign hdr_discard = bus.drop || (bus.select >= SEL_W'(M_COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (hdr_fire) state_next = ACTIVE;
      ACTIVE: if (pay_fire && bus.s_eth_payload_axis_tlast) state_next = IDLE;
    endcase
  end

  // Handshake readies; the rst_n term keeps the header closed while reset is asserted.
  always_comb begin
    hdr_ready = 1'b0;
    pay_ready = 1'b0;
    case (state)
      IDLE:   hdr_ready = rst_n && bus.enable && (hdr_valid_reg == '0);
      ACTIVE: pay_ready = drop_reg || (pay_valid_reg == '0) || stage_ready;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg       <= '0;
      drop_reg      <= 1'b0;
      hdr_valid_reg <= '0;
      pay_valid_reg <= '0;
      dest_mac_reg  <= '0;
      src_mac_reg   <= '0;
      type_reg      <= '0;
      tdata_reg     <= '0;
      tlast_reg     <= 1'b0;
      tuser_reg     <= '0;
    end else begin
      hdr_valid_reg <= hdr_valid_reg & ~bus.m_eth_hdr_ready;
      if (hdr_fire) begin
        sel_reg  <= bus.select;
        drop_reg <= hdr_discard;
        if (!hdr_discard) begin
          hdr_valid_reg <= M_COUNT'(1) << bus.select;
          dest_mac_reg  <= bus.s_eth_dest_mac;
          src_mac_reg   <= bus.s_eth_src_mac;
          type_reg      <= bus.s_eth_type;
        end
      end
      if (pay_fire && !drop_reg) begin
        pay_valid_reg <= M_COUNT'(1) << sel_reg;
        tdata_reg     <= bus.s_eth_payload_axis_tdata;
        tlast_reg     <= bus.s_eth_payload_axis_tlast;
        tuser_reg     <= bus.s_eth_payload_axis_tuser;
      end else if (stage_ready) begin
        pay_valid_reg <= '0;
      end
    end
  end

  assign bus.s_eth_hdr_ready           = hdr_ready;
  assign bus.s_eth_payload_axis_tready = pay_ready;
  assign bus.m_eth_hdr_valid           = hdr_valid_reg;
  assign bus.m_eth_dest_mac            = dest_mac_reg;
  assign bus.m_eth_src_mac             = src_mac_reg;
  assign bus.m_eth_type                = type_reg;
  assign bus.m_eth_payload_axis_tvalid = pay_valid_reg;
  assign bus.m_eth_payload_axis_tdata  = tdata_reg;
  assign bus.m_eth_payload_axis_tlast  = tlast_reg;
  assign bus.m_eth_payload_axis_tuser  = tuser_reg;
endmodule
